// File: rtl/robot_step_scheduler.sv
// robot_step_scheduler
// Runs the pipe-cleaning robot one step per tick: fetch head/left/under
// map cells, present them to the robot, wait for its action and commit the
// new pose. Also shares the single-port map ROM with the VGA renderer.
// Optional build macro: ROBOT_WATCHDOG_EN (adds robot_timeout and a
// 64-cycle limit on how long the robot may take to answer).

module robot_step_scheduler #(
  parameter int         TICK_DIV     = 16,
  parameter int         MAP_ROWS     = 10,
  parameter int         MAP_COLS     = 20,
  parameter int         START_ROW    = 1,
  parameter int         START_COL    = 1,
  parameter logic [1:0] START_ORIENT = 2'b10,
  parameter int         STARVE_MAX   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       vga_req,
  input  logic [5:0] vga_row,
  input  logic [5:0] vga_col,
  output logic       vga_grant,
  output logic       vga_rd_valid,
  output logic [1:0] vga_cell,
  output logic [5:0] map_row,
  output logic [5:0] map_col,
  input  logic [1:0] map_data,
  output logic       robot_step_req,
  output logic       robot_head,
  output logic       robot_left,
  output logic       robot_under,
  input  logic       robot_ack,
  input  logic [2:0] robot_action,
  output logic [5:0] robot_row,
  output logic [5:0] robot_column,
  output logic [1:0] robot_orientation,
  output logic       step_done,
  output logic       bump,
  output logic [7:0] overrun_cnt
`ifdef ROBOT_WATCHDOG_EN
  ,
  output logic       robot_timeout
`endif
);

  localparam int              TW         = $clog2(TICK_DIV);
  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [5:0]      ROWS_MAX   = 6'(MAP_ROWS);
  localparam logic [5:0]      COLS_MAX   = 6'(MAP_COLS);
  localparam logic [1:0]      NORTH      = 2'b00;
  localparam logic [1:0]      SOUTH      = 2'b01;
  localparam logic [1:0]      EAST       = 2'b10;
  localparam logic [1:0]      WEST       = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_HEAD, RD_LEFT, RD_UNDER, PRESENT, COMMIT} state_t;
  typedef enum logic [1:0] {LAT_NONE, LAT_HEAD, LAT_LEFT, LAT_UNDER} lat_t;

  state_t        state, state_nx;
  lat_t          lat_sel, lat_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] starve_cnt;
  logic [5:0]    row_q, col_q;
  logic [1:0]    orient_q;
  logic          head_q, left_q, under_q, bump_q, vga_valid_q;
  logic [11:0]   head_tgt, left_tgt, tgt;
  logic          tgt_on, rd_state, sched_req, override, sched_grant, rd_advance, ack_fire;
  logic          wd_expire;

  function automatic logic [11:0] neighbour(input logic [5:0] r, input logic [5:0] c,
                                            input logic [1:0] d);
    logic [11:0] res;
    res = {r, c};
    case (d)
      NORTH:   res = {r - 6'd1, c};
      SOUTH:   res = {r + 6'd1, c};
      EAST:    res = {r, c + 6'd1};
      default: res = {r, c - 6'd1};
    endcase
    return res;
  endfunction

  function automatic logic [1:0] turn_left(input logic [1:0] d);
    logic [1:0] res;
    res = NORTH;
    case (d)
      NORTH:   res = WEST;
      WEST:    res = SOUTH;
      SOUTH:   res = EAST;
      default: res = NORTH;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] turn_right(input logic [1:0] d);
    logic [1:0] res;
    res = NORTH;
    case (d)
      NORTH:   res = EAST;
      EAST:    res = SOUTH;
      SOUTH:   res = WEST;
      default: res = NORTH;
    endcase
    return res;
  endfunction

  function automatic logic on_map(input logic [5:0] r, input logic [5:0] c);
    return (r != 6'd0) && (r <= ROWS_MAX) && (c != 6'd0) && (c <= COLS_MAX);
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign head_tgt  = neighbour(row_q, col_q, orient_q);
  assign left_tgt  = neighbour(row_q, col_q, turn_left(orient_q));
  assign rd_state  = (state == RD_HEAD) || (state == RD_LEFT) || (state == RD_UNDER);
  assign tgt_on    = on_map(tgt[11:6], tgt[5:0]);
  assign sched_req = rd_state && tgt_on;
  assign override  = sched_req && (starve_cnt == STARVE_LIM);
  assign vga_grant = vga_req && !override;
  assign sched_grant = sched_req && !vga_grant;
  assign rd_advance  = rd_state && (!tgt_on || sched_grant);
  assign ack_fire    = (state == PRESENT) && robot_ack;

  // Free-running step tick divider
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Count ticks that arrive while a step is still in flight, saturating
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                                 overrun_cnt <= 8'd0;
    else if (tick && (state != IDLE) && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
  end

  // Pick the cell the current read state wants
  always_comb begin
    tgt = head_tgt;
    case (state)
      RD_LEFT:  tgt = left_tgt;
      RD_UNDER: tgt = {row_q, col_q};
      default:  tgt = head_tgt;
    endcase
  end

  // Drive the map port from whoever holds it this cycle
  always_comb begin
    map_row = 6'd0;
    map_col = 6'd0;
    if (vga_grant) begin
      map_row = vga_row;
      map_col = vga_col;
    end else if (sched_grant) begin
      map_row = tgt[11:6];
      map_col = tgt[5:0];
    end
  end

  // Starvation counter: forces one scheduler cycle after a long VGA run
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                          starve_cnt <= '0;
    else if (sched_grant)                                starve_cnt <= '0;
    else if (sched_req && (starve_cnt != STARVE_LIM))    starve_cnt <= starve_cnt + 1'b1;
  end

`ifdef ROBOT_WATCHDOG_EN
  logic [5:0] wd_cnt;
  logic       timeout_q;
  assign wd_expire     = (state == PRESENT) && !robot_ack && (wd_cnt == 6'd63);
  assign robot_timeout = timeout_q;

  // Time how long the robot has been sitting on its decision
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt    <= ((state == PRESENT) && !robot_ack) ? wd_cnt + 6'd1 : 6'd0;
      timeout_q <= wd_expire;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Step sequencer state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lat_sel <= LAT_NONE;
    end else begin
      state   <= state_nx;
      lat_sel <= lat_nx;
    end
  end

  // Step sequencer next state and which sensor the port data belongs to
  always_comb begin
    state_nx = state;
    lat_nx   = LAT_NONE;
    case (state)
      IDLE:     if (tick && enable) state_nx = RD_HEAD;
      RD_HEAD: begin
        if (sched_grant) lat_nx = LAT_HEAD;
        if (rd_advance)  state_nx = RD_LEFT;
      end
      RD_LEFT: begin
        if (sched_grant) lat_nx = LAT_LEFT;
        if (rd_advance)  state_nx = RD_UNDER;
      end
      RD_UNDER: begin
        if (sched_grant) lat_nx = LAT_UNDER;
        if (rd_advance)  state_nx = PRESENT;
      end
      PRESENT:  if (ack_fire || wd_expire) state_nx = COMMIT;
      COMMIT:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Capture sensor values; off-map targets read as walls without a fetch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= 1'b0;
      left_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      if (lat_sel == LAT_HEAD)                 head_q <= map_data[0];
      else if ((state == RD_HEAD) && !tgt_on)  head_q <= 1'b1;
      if (lat_sel == LAT_LEFT)                 left_q <= map_data[0];
      else if ((state == RD_LEFT) && !tgt_on)  left_q <= 1'b1;
      if (lat_sel == LAT_UNDER)                under_q <= (map_data == 2'b10);
    end
  end

  // Apply the robot's chosen action on the edge that ends the ack cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q    <= 6'(START_ROW);
      col_q    <= 6'(START_COL);
      orient_q <= START_ORIENT;
      bump_q   <= 1'b0;
    end else begin
      bump_q <= ack_fire && (robot_action == 3'b001) && head_q;
      if (ack_fire) begin
        case (robot_action)
          3'b001: if (!head_q) begin
            row_q <= head_tgt[11:6];
            col_q <= head_tgt[5:0];
          end
          3'b010:  orient_q <= turn_left(orient_q);
          3'b011:  orient_q <= turn_right(orient_q);
          default: ;
        endcase
      end
    end
  end

  // VGA read data is valid the cycle after its grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vga_valid_q <= 1'b0;
    else        vga_valid_q <= vga_grant;
  end

  assign vga_rd_valid      = vga_valid_q;
  assign vga_cell          = map_data;
  assign robot_step_req    = (state == PRESENT);
  assign robot_head        = head_q;
  assign robot_left        = left_q;
  assign robot_under       = (lat_sel == LAT_UNDER) ? (map_data == 2'b10) : under_q;
  assign robot_row         = row_q;
  assign robot_column      = col_q;
  assign robot_orientation = orient_q;
  assign step_done         = (state == COMMIT);
  assign bump              = bump_q;

endmodule

// File: tb/tb_robot_step_scheduler.sv
// Directed testbench for robot_step_scheduler (TICK_DIV = 8).
// A behavioural map ROM answers one cycle after each address.

module tb_robot_step_scheduler;

  localparam int TICK = 8;

  logic       clock, reset, enable, vga_req;
  logic [5:0] vga_row, vga_col;
  logic       vga_grant, vga_rd_valid;
  logic [1:0] vga_cell;
  logic [5:0] map_row, map_col;
  logic [1:0] map_data;
  logic       robot_step_req, robot_head, robot_left, robot_under;
  logic       robot_ack;
  logic [2:0] robot_action;
  logic [5:0] robot_row, robot_column;
  logic [1:0] robot_orientation;
  logic       step_done, bump;
  logic [7:0] overrun_cnt;

  int vectors = 0;
  int miscompares = 0;
  int tb_cnt;
  logic [1:0] map_mem [0:63][0:63];

  robot_step_scheduler #(.TICK_DIV(TICK)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .vga_req(vga_req), .vga_row(vga_row), .vga_col(vga_col),
    .vga_grant(vga_grant), .vga_rd_valid(vga_rd_valid), .vga_cell(vga_cell),
    .map_row(map_row), .map_col(map_col), .map_data(map_data),
    .robot_step_req(robot_step_req), .robot_head(robot_head),
    .robot_left(robot_left), .robot_under(robot_under),
    .robot_ack(robot_ack), .robot_action(robot_action),
    .robot_row(robot_row), .robot_column(robot_column),
    .robot_orientation(robot_orientation),
    .step_done(step_done), .bump(bump), .overrun_cnt(overrun_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Map ROM model: one-cycle read latency
  always @(posedge clock) map_data <= map_mem[map_row][map_col];

  // Tick phase reference, independent of the DUT
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_cnt <= 0;
    else        tb_cnt <= tb_cnt + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic clear_map;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        map_mem[r][c] = 2'b00;
  endtask

  task automatic apply_reset;
    @(negedge clock);
    reset = 1'b0; robot_ack = 1'b0; vga_req = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (robot_step_req === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (tb_cnt % TICK == TICK - 1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ack_now(input logic [2:0] act);
    robot_ack = 1'b1; robot_action = act;
    @(negedge clock);
    robot_ack = 1'b0; robot_action = 3'b000;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; vga_req = 1'b0; vga_row = 6'd0; vga_col = 6'd0;
    robot_ack = 1'b0; robot_action = 3'b000;
    clear_map();
    #2 reset = 1'b0;
    #2;
    vectors++;
    if ({robot_row, robot_column, robot_orientation} !== {6'd1, 6'd1, 2'b10}) begin
      miscompares++;
      $display("[TB] FAIL reset_pose: got %0d,%0d,%b required 1,1,10", robot_row, robot_column, robot_orientation);
    end
    vectors++;
    if ({robot_step_req, step_done, bump, vga_rd_valid, robot_head, robot_left, robot_under} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b required 0000000",
               {robot_step_req, step_done, bump, vga_rd_valid, robot_head, robot_left, robot_under});
    end
    vectors++;
    if (overrun_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_overrun: got %0d required 0", overrun_cnt);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_forward;
    bit ok;
    apply_reset();
    clear_map();
    map_mem[1][3] = 2'b10;
    for (int s = 1; s <= 3; s++) begin
      wait_req(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("[TB] FAIL fwd_req_timeout step %0d: got no request required request", s);
      end else begin
        vectors++;
        if (tb_cnt % TICK != 3) begin
          miscompares++;
          $display("[TB] FAIL fwd_latency step %0d: got phase %0d required 3", s, tb_cnt % TICK);
        end
        vectors++;
        if ({robot_head, robot_under} !== {1'b0, 1'(s == 3)}) begin
          miscompares++;
          $display("[TB] FAIL fwd_sensors step %0d: got %b required %b", s, {robot_head, robot_under}, {1'b0, 1'(s == 3)});
        end
        ack_now(3'b001);
        vectors++;
        if ({step_done, bump, robot_column} !== {2'b10, 6'(s + 1)}) begin
          miscompares++;
          $display("[TB] FAIL fwd_commit step %0d: got done=%b bump=%b col=%0d required 1 0 %0d", s, step_done, bump, robot_column, s + 1);
        end
      end
    end
    vectors++;
    if ({robot_row, robot_column, overrun_cnt} !== {6'd1, 6'd4, 8'd0}) begin
      miscompares++;
      $display("[TB] FAIL fwd_final: got row=%0d col=%0d ovr=%0d required 1 4 0", robot_row, robot_column, overrun_cnt);
    end
  endtask

  task automatic test_bump;
    bit ok;
    apply_reset();
    clear_map();
    map_mem[1][3] = 2'b01;
    wait_req(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL bump_req1: got no request required request"); end
    ack_now(3'b001);
    wait_req(ok);
    vectors++;
    if (!ok || robot_head !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bump_head: got ok=%b head=%b required 1 1", ok, robot_head);
    end
    ack_now(3'b001);
    vectors++;
    if ({robot_row, robot_column, bump, step_done} !== {6'd1, 6'd2, 2'b11}) begin
      miscompares++;
      $display("[TB] FAIL bump_commit: got %0d,%0d bump=%b done=%b required 1,2 1 1", robot_row, robot_column, bump, step_done);
    end
    @(negedge clock);
    vectors++;
    if ({bump, step_done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL bump_pulse: got %b required 00", {bump, step_done});
    end
  endtask

  task automatic test_offmap_head;
    bit ok;
    apply_reset();
    clear_map();
    map_mem[1][6] = 2'b01;
    map_mem[2][5] = 2'b01;
    for (int s = 0; s < 4; s++) begin
      wait_req(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL offmap_setup_req %0d: got no request required request", s); end
      ack_now(3'b001);
    end
    wait_req(ok);
    vectors++;
    if (!ok || robot_head !== 1'b1 || robot_column !== 6'd5) begin
      miscompares++;
      $display("[TB] FAIL offmap_east_wall: got ok=%b head=%b col=%0d required 1 1 5", ok, robot_head, robot_column);
    end
    ack_now(3'b010);
    vectors++;
    if (robot_orientation !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL offmap_face_north: got %b required 00", robot_orientation);
    end
    wait_tick(ok);
    @(negedge clock);
    vectors++;
    if ({map_row, map_col} === {6'd0, 6'd5}) begin
      miscompares++;
      $display("[TB] FAIL offmap_no_read: got address 0,5 required any other");
    end
    @(negedge clock);
    vectors++;
    if ({map_row, map_col} !== {6'd1, 6'd4}) begin
      miscompares++;
      $display("[TB] FAIL offmap_left_addr: got %0d,%0d required 1,4", map_row, map_col);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if ({robot_step_req, robot_head, robot_left, robot_under} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL offmap_sensors: got %b required 1100", {robot_step_req, robot_head, robot_left, robot_under});
    end
    ack_now(3'b000);
    vectors++;
    if ({robot_row, robot_column, robot_orientation} !== {6'd1, 6'd5, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL offmap_stay: got %0d,%0d,%b required 1,5,00", robot_row, robot_column, robot_orientation);
    end
  endtask

  task automatic test_turns;
    bit ok;
    logic [1:0] exp_or [4];
    exp_or = '{2'b11, 2'b01, 2'b10, 2'b00};
    for (int s = 0; s < 4; s++) begin
      wait_req(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL turn_req %0d: got no request required request", s); end
      ack_now(3'b010);
      vectors++;
      if ({robot_row, robot_column, robot_orientation} !== {6'd1, 6'd5, exp_or[s]}) begin
        miscompares++;
        $display("[TB] FAIL turn_left %0d: got %0d,%0d,%b required 1,5,%b", s, robot_row, robot_column, robot_orientation, exp_or[s]);
      end
    end
  endtask

  task automatic test_enable;
    bit ok;
    bit saw;
    enable = 1'b0;
    saw = 1'b0;
    repeat (24) begin
      @(negedge clock);
      if (robot_step_req === 1'b1) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0 || overrun_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL enable_low: got req_seen=%b ovr=%0d required 0 0", saw, overrun_cnt);
    end
    enable = 1'b1;
    wait_tick(ok);
    @(negedge clock);
    enable = 1'b0;
    wait_req(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL enable_midstep_req: got no request required request"); end
    ack_now(3'b000);
    vectors++;
    if (step_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL enable_midstep_done: got %b required 1", step_done);
    end
    enable = 1'b1;
  endtask

  task automatic test_vga;
    bit ok;
    logic [11:0] exp_addr [3];
    exp_addr = '{{6'd2, 6'd2}, {6'd1, 6'd3}, {6'd1, 6'd2}};
    apply_reset();
    clear_map();
    map_mem[1][2] = 2'b10;
    map_mem[1][3] = 2'b11;
    map_mem[2][2] = 2'b01;
    map_mem[7][7] = 2'b10;
    wait_req(ok);
    vectors++;
    if (!ok || robot_head !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL vga_setup1: got ok=%b head=%b required 1 0", ok, robot_head);
    end
    ack_now(3'b001);
    wait_req(ok);
    ack_now(3'b011);
    vectors++;
    if ({robot_row, robot_column, robot_orientation} !== {6'd1, 6'd2, 2'b01}) begin
      miscompares++;
      $display("[TB] FAIL vga_setup_turn_right: got %0d,%0d,%b required 1,2,01", robot_row, robot_column, robot_orientation);
    end
    wait_tick(ok);
    vga_req = 1'b1; vga_row = 6'd7; vga_col = 6'd7;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clock);
      vectors++;
      if (vga_grant !== 1'(k % 9 != 0)) begin
        miscompares++;
        $display("[TB] FAIL vga_grant cycle %0d: got %b required %b", k, vga_grant, 1'(k % 9 != 0));
      end
      if (k % 9 == 0) begin
        vectors++;
        if ({map_row, map_col} !== exp_addr[k / 9 - 1]) begin
          miscompares++;
          $display("[TB] FAIL vga_sched_addr cycle %0d: got %0d,%0d required %0d,%0d", k, map_row, map_col,
                   exp_addr[k / 9 - 1][11:6], exp_addr[k / 9 - 1][5:0]);
        end
      end
      if (k == 2) begin
        vectors++;
        if ({vga_rd_valid, vga_cell} !== 3'b110) begin
          miscompares++;
          $display("[TB] FAIL vga_data: got valid=%b cell=%b required 1 10", vga_rd_valid, vga_cell);
        end
      end
      if (k == 10) begin
        vectors++;
        if (vga_rd_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL vga_valid_after_override: got %b required 0", vga_rd_valid);
        end
      end
      if (k == 27) begin
        vectors++;
        if (robot_step_req !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL vga_req_early: got %b required 0", robot_step_req);
        end
      end
    end
    @(negedge clock);
    vectors++;
    if ({robot_step_req, robot_head, robot_left, robot_under} !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL vga_sensors: got %b required 1111", {robot_step_req, robot_head, robot_left, robot_under});
    end
    ack_now(3'b000);
    vga_req = 1'b0;
    vectors++;
    if (overrun_cnt !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL vga_overrun: got %0d required 3", overrun_cnt);
    end
  endtask

  task automatic test_overrun;
    bit ok;
    apply_reset();
    clear_map();
    wait_req(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL ovr_req: got no request required request"); end
    repeat (20) @(negedge clock);
    vectors++;
    if (robot_step_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovr_req_held: got %b required 1", robot_step_req);
    end
    ack_now(3'b001);
    vectors++;
    if ({overrun_cnt, robot_column, step_done} !== {8'd3, 6'd2, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ovr_count: got ovr=%0d col=%0d done=%b required 3 2 1", overrun_cnt, robot_column, step_done);
    end
    wait_req(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL ovr_req2: got no request required request"); end
    reset = 1'b0;
    #1;
    vectors++;
    if ({robot_row, robot_column, robot_orientation, overrun_cnt, robot_step_req} !== {6'd1, 6'd1, 2'b10, 8'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL ovr_reset_midstep: got %0d,%0d,%b ovr=%0d req=%b required 1,1,10 0 0",
               robot_row, robot_column, robot_orientation, overrun_cnt, robot_step_req);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_bump();
    test_offmap_head();
    test_turns();
    test_enable();
    test_vga();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
